i2c_slave_rx: RTL

Write-only I2C target (slave) receiver, the far end of the team's `i2c_master` link. It oversamples SCL/SDA on the system clock, detects START and STOP, and matches the first byte against `dev_address`. It then receives exactly two data bytes, most-significant byte first, ACKing each by pulling SDA low. A complete frame is presented as a 16-bit `reg_data` word with a one-cycle `data_valid` strobe to the register block behind it.

---
 rtl/i2c_slave_rx_if.sv | 24 ++
 rtl/i2c_slave_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx_if.sv
// Bus-side signal bundle for the write-only I2C target receiver.
// The slave modport is the receiver's view; the master modport is the pad/register-block side.
interface i2c_slave_rx_if;
  logic        scl_in;
  logic        sda_in;
  logic [7:0]  dev_address;
  logic        sda_drive_low;
  logic [15:0] reg_data;
  logic        data_valid;
  logic        busy;
  logic        error;
  logic [7:0]  state;
  logic [3:0]  bit_count;

  modport slave (
    input  scl_in, sda_in, dev_address,
    output sda_drive_low, reg_data, data_valid, busy, error, state, bit_count
  );

  modport master (
    output scl_in, sda_in, dev_address,
    input  sda_drive_low, reg_data, data_valid, busy, error, state, bit_count
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversamples SCL/SDA, matches the address byte, ACKs and
// collects exactly two data bytes into a 16-bit word with a one-cycle valid strobe.
module i2c_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  i2c_slave_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_q, r_sda_q;
  logic                   w_scl_s, w_sda_s;
  logic                   w_start, w_stop, w_scl_rise, w_scl_fall;

  state_t      r_state,     w_state_nxt;
  logic [3:0]  r_bit_count, w_bit_count_nxt;
  logic [1:0]  r_byte_idx,  w_byte_idx_nxt;
  logic [7:0]  r_shift,     w_shift_nxt;
  logic [7:0]  r_high,      w_high_nxt;
  logic [15:0] r_reg_data,  w_reg_data_nxt;
  logic        r_sda_drive_low, w_sda_drive_low_nxt;
  logic        r_data_valid,    w_data_valid_nxt;
  logic        r_busy,          w_busy_nxt;
  logic        r_error,         w_error_nxt;
  logic        w_matched;

  // Synchronizers reset to 1 (idle bus) so no phantom edge appears after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what turns this into a shift chain.
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_q    <= w_scl_s;
      r_sda_q    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_start    = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;
  assign w_scl_rise = ~r_scl_q & w_scl_s;
  assign w_scl_fall = r_scl_q & ~w_scl_s;

  // Only these states can be reached after a successful address match.
  assign w_matched = (r_state == S_ADDR_ACK) || (r_state == S_DATA) || (r_state == S_DATA_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_bit_count     <= 4'd0;
      r_byte_idx      <= 2'd0;
      r_shift         <= 8'd0;
      r_high          <= 8'd0;
      r_reg_data      <= 16'd0;
      r_sda_drive_low <= 1'b0;
      r_data_valid    <= 1'b0;
      r_busy          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_bit_count     <= w_bit_count_nxt;
      r_byte_idx      <= w_byte_idx_nxt;
      r_shift         <= w_shift_nxt;
      r_high          <= w_high_nxt;
      r_reg_data      <= w_reg_data_nxt;
      r_sda_drive_low <= w_sda_drive_low_nxt;
      r_data_valid    <= w_data_valid_nxt;
      r_busy          <= w_busy_nxt;
      r_error         <= w_error_nxt;
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default up front so no path through the case leaves one unassigned and infers a latch.
    w_state_nxt         = r_state;
    w_bit_count_nxt     = r_bit_count;
    w_byte_idx_nxt      = r_byte_idx;
    w_shift_nxt         = r_shift;
    w_high_nxt          = r_high;
    w_reg_data_nxt      = r_reg_data;
    w_sda_drive_low_nxt = r_sda_drive_low;
    w_busy_nxt          = r_busy;
    w_data_valid_nxt    = 1'b0;
    w_error_nxt         = 1'b0;

    if (w_scl_rise && (r_state == S_ADDR || r_state == S_DATA) && r_bit_count < 4'd8) begin
      w_shift_nxt     = {r_shift[6:0], w_sda_s};
      w_bit_count_nxt = r_bit_count + 4'd1;
    end

    if (w_start || w_stop) begin
      w_sda_drive_low_nxt = 1'b0;
      if (w_matched && r_byte_idx < 2'd2) w_error_nxt = 1'b1;
      if (w_start) begin
        w_state_nxt     = S_ADDR;
        w_bit_count_nxt = 4'd0;
        w_byte_idx_nxt  = 2'd0;
        w_busy_nxt      = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_fall && r_bit_count == 4'd8) begin
            if (r_shift == bus.dev_address) begin
              w_sda_drive_low_nxt = 1'b1;
              w_state_nxt         = S_ADDR_ACK;
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            w_sda_drive_low_nxt = 1'b0;
            w_bit_count_nxt     = 4'd0;
            w_state_nxt         = S_DATA;
          end
        end
        S_DATA: begin
          if (w_scl_fall && r_bit_count == 4'd8) begin
            case (r_byte_idx)
              2'd0: begin
                w_high_nxt          = r_shift;
                w_sda_drive_low_nxt = 1'b1;
                w_byte_idx_nxt      = 2'd1;
                w_state_nxt         = S_DATA_ACK;
              end
              2'd1: begin
                w_reg_data_nxt      = {r_high, r_shift};
                w_data_valid_nxt    = 1'b1;
                w_sda_drive_low_nxt = 1'b1;
                w_byte_idx_nxt      = 2'd2;
                w_state_nxt         = S_DATA_ACK;
              end
              default: begin
                w_error_nxt = 1'b1;
                w_state_nxt = S_IGNORE;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_drive_low = r_sda_drive_low;
  assign bus.reg_data      = r_reg_data;
  assign bus.data_valid    = r_data_valid;
  assign bus.busy          = r_busy;
  assign bus.error         = r_error;
  assign bus.state         = {5'd0, r_state};
  assign bus.bit_count     = r_bit_count;

endmodule
